equilibrium_maxxing_uc: RTL
===========================

# equilibrium_maxxing_uc

Control unit (UC) for the EquilibriumMaxxing datapath. It sequences one game session: pendulum calibration, difficulty capture, preparation delay, round generation, LED fade, and play window. It counts hits and misses, raises the level after a configurable number of hits, and ends the game after a configurable number of misses. It drives every control input of the FD and consumes the FD's status pulses.

## Interface
- `ROUNDS_PER_LEVEL`, default 8: hits needed before `conta_nivel` is pulsed (≥1).
- `MAX_MISSES`, default 3: misses that end the game (≥1).
- `PLAY_TIMEOUT`, default 50_000_000: cycles allowed in the play window before the round counts as a miss (≥2).
- `TIMEOUT_W`, default 26: width of the timeout counter; must satisfy 2^TIMEOUT_W > PLAY_TIMEOUT.
- `clock` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-low. State returns to IDLE and all counters clear.
- `iniciar` input 1: synchronous start request, sampled in IDLE and FIM.
- `parar` input 1: synchronous abort, forces IDLE from any state.
- `calib_done` input 1: level signal from the FD; calibration finished.
- `prep_done` input 1: FD preparation counter reached its end.
- `ganhou_ponto` input 1: FD pulse, target hit.
- `perdeu_ponto` input 1: FD pulse, target missed.
- `calib_start` output 1: held high during CALIB.
- `trava_servo` output 1: held high in IDLE, INIT and FIM.
- `start_game` output 1: one-cycle pulse in SELECT.
- `reset_prep_cnt` output 1: one-cycle pulse in SELECT and ESPERA.
- `reset_nivel` output 1: one-cycle pulse in INIT; clears score and level.
- `reset_nivel_locked` output 1: one-cycle pulse in INIT; clears the level register.
- `gerar_nova_jogada` output 1: one-cycle pulse in NOVA.
- `fade_trigger` output 1: one-cycle pulse in FADE.
- `conta_nivel` output 1: one-cycle pulse in NIVEL.
- `fim_jogo` output 1: held high in FIM.
- `db_estado` output 4: state encoding, for the debug display.

## Operation
- States and encodings:
  - IDLE=0, INIT=1, CALIB=2, SELECT=3, PREP=4, NOVA=5, FADE=6, JOGA=7
  - ACERTO=8, ERRO=9, NIVEL=10, ESPERA=11, FIM=12
  - Codes 13–15 are unused and go to IDLE on the next cycle.
- Transitions:
  - IDLE: `iniciar` → INIT.
  - INIT → CALIB unconditionally. Clears `rounds` and `misses`.
  - CALIB: `calib_done` → SELECT.
  - SELECT → PREP.
  - PREP: `prep_done` → NOVA.
  - NOVA → FADE. Clears the timeout counter.
  - FADE → JOGA.
  - JOGA: checked in this priority order:
    - `perdeu_ponto` → ERRO.
    - else `ganhou_ponto` → ACERTO.
    - else timeout counter = PLAY_TIMEOUT−1 → ERRO.
    - else increment the timeout counter.
  - ACERTO: if `rounds` = ROUNDS_PER_LEVEL−1, clear `rounds` → NIVEL; else increment `rounds` → ESPERA.
  - ERRO: if `misses` = MAX_MISSES−1 → FIM; else increment `misses` → ESPERA.
  - NIVEL → ESPERA.
  - ESPERA → PREP.
  - FIM: `iniciar` → INIT.
- `parar` has priority over every transition except in IDLE: next state is IDLE and counters clear. `parar` and `iniciar` together in IDLE → INIT.
- Outputs are Moore, decoded from the state register only. Pulses are therefore exactly one cycle because their states last one cycle.
- Counter widths: `rounds` and `misses` are sized by `$clog2` of their parameter (minimum 1 bit). They never wrap, because they are compared before increment.
- Inputs are assumed synchronous to `clock`. FD status pulses arriving outside JOGA are ignored.

## Timing
- Reset values:
  - state IDLE, `db_estado`=0
  - `trava_servo`=1
  - all other outputs 0
  - all counters 0
- `iniciar` sampled high at edge t produces:
  - INIT during cycle t+1: `reset_nivel` and `reset_nivel_locked` high.
  - CALIB from t+2: `calib_start` high.
- `calib_done` high at edge t: SELECT (`start_game` and `reset_prep_cnt` high) during t+1, PREP from t+2.
- `prep_done` in PREP: NOVA at +1, FADE at +2, JOGA at +3.
- Play window: the timeout fires after exactly PLAY_TIMEOUT cycles spent in JOGA.
- Result to next PREP:
  - Hit, no level-up: 2 cycles (ACERTO, ESPERA).
  - Hit with level-up: 3 cycles (ACERTO, NIVEL, ESPERA).
  - Miss: 2 cycles (ERRO, ESPERA).
- Async reset mid-operation returns IDLE immediately. Pulses in progress are truncated.

## Test plan
Directed scenarios use PLAY_TIMEOUT=20, ROUNDS_PER_LEVEL=2, MAX_MISSES=2.
- Reset released → `db_estado`=0, `trava_servo`=1, all other outputs 0. `ganhou_ponto` pulses are ignored.
- Start sequence: `iniciar` pulse → `reset_nivel` and `reset_nivel_locked` high for 1 cycle, then `calib_start` high until `calib_done`; `start_game` pulses once; `prep_done` → `gerar_nova_jogada` and `fade_trigger` on consecutive cycles; `db_estado`=7.
- Two hits: `ganhou_ponto` in two rounds → first round passes ACERTO→ESPERA; second produces one `conta_nivel` pulse; `db_estado` sequence 8,10,11,4.
- Timeout: no FD pulse in JOGA → ERRO exactly 20 cycles after entering JOGA. A second timeout → FIM with `fim_jogo`=1 and `trava_servo`=1.
- Simultaneous `ganhou_ponto` and `perdeu_ponto` in JOGA → ERRO. From FIM, `iniciar` → INIT with counters cleared.
- Abort and mid-game reset: `parar` during PREP → IDLE next cycle. `reset` low during JOGA → IDLE asynchronously; outputs return to reset values.

Source files
------------

// File: rtl/equilibrium_maxxing_uc_if.sv
// Control/status link between the EquilibriumMaxxing UC (master) and its FD (slave).
interface equilibrium_maxxing_uc_if;
  // FD status toward the UC
  logic calib_done;
  logic prep_done;
  logic ganhou_ponto;
  logic perdeu_ponto;
  // UC controls toward the FD
  logic calib_start;
  logic trava_servo;
  logic start_game;
  logic reset_prep_cnt;
  logic reset_nivel;
  logic reset_nivel_locked;
  logic gerar_nova_jogada;
  logic fade_trigger;
  logic conta_nivel;

  modport master (
    input  calib_done, prep_done, ganhou_ponto, perdeu_ponto,
    output calib_start, trava_servo, start_game, reset_prep_cnt,
           reset_nivel, reset_nivel_locked, gerar_nova_jogada,
           fade_trigger, conta_nivel
  );

  modport slave (
    output calib_done, prep_done, ganhou_ponto, perdeu_ponto,
    input  calib_start, trava_servo, start_game, reset_prep_cnt,
           reset_nivel, reset_nivel_locked, gerar_nova_jogada,
           fade_trigger, conta_nivel
  );
endinterface

// File: rtl/equilibrium_maxxing_uc.sv
// EquilibriumMaxxing control unit: sequences calibration, rounds, scoring and game end.
module equilibrium_maxxing_uc #(
  parameter int unsigned ROUNDS_PER_LEVEL = 8,
  parameter int unsigned MAX_MISSES       = 3,
  parameter int unsigned PLAY_TIMEOUT     = 50_000_000,
  parameter int unsigned TIMEOUT_W        = 26
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      iniciar,
  input  logic                      parar,
  equilibrium_maxxing_uc_if.master  fd,
  output logic                      fim_jogo,
  output logic [3:0]                db_estado
);

  localparam int unsigned RW = (ROUNDS_PER_LEVEL > 1) ? $clog2(ROUNDS_PER_LEVEL) : 1;
  localparam int unsigned MW = (MAX_MISSES > 1) ? $clog2(MAX_MISSES) : 1;

  localparam logic [RW-1:0]        ROUNDS_LAST = RW'(ROUNDS_PER_LEVEL - 1);
  localparam logic [MW-1:0]        MISSES_LAST = MW'(MAX_MISSES - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST    = TIMEOUT_W'(PLAY_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    INIT   = 4'd1,
    CALIB  = 4'd2,
    SELECT = 4'd3,
    PREP   = 4'd4,
    NOVA   = 4'd5,
    FADE   = 4'd6,
    JOGA   = 4'd7,
    ACERTO = 4'd8,
    ERRO   = 4'd9,
    NIVEL  = 4'd10,
    ESPERA = 4'd11,
    FIM    = 4'd12
  } state_t;

  state_t                state, state_next;
  logic [RW-1:0]         rounds;
  logic [MW-1:0]         misses;
  logic [TIMEOUT_W-1:0]  tmo;
  logic                  abort;

  // parar wins everywhere except IDLE, where iniciar still starts the game
  assign abort = parar && (state != IDLE);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode; counters are compared before they would be incremented
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (iniciar) state_next = INIT;
        INIT:    state_next = CALIB;
        CALIB:   if (fd.calib_done) state_next = SELECT;
        SELECT:  state_next = PREP;
        PREP:    if (fd.prep_done) state_next = NOVA;
        NOVA:    state_next = FADE;
        FADE:    state_next = JOGA;
        JOGA: begin
          if (fd.perdeu_ponto)      state_next = ERRO;
          else if (fd.ganhou_ponto) state_next = ACERTO;
          else if (tmo == TMO_LAST) state_next = ERRO;
        end
        ACERTO:  state_next = (rounds == ROUNDS_LAST) ? NIVEL : ESPERA;
        ERRO:    state_next = (misses == MISSES_LAST) ? FIM : ESPERA;
        NIVEL:   state_next = ESPERA;
        ESPERA:  state_next = PREP;
        FIM:     if (iniciar) state_next = INIT;
        default: state_next = IDLE;
      endcase
    end
  end

  // Round, miss and play-window counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rounds <= '0;
      misses <= '0;
      tmo    <= '0;
    end else if (abort) begin
      rounds <= '0;
      misses <= '0;
      tmo    <= '0;
    end else begin
      case (state)
        INIT: begin
          rounds <= '0;
          misses <= '0;
        end
        NOVA: tmo <= '0;
        JOGA:
          if (!fd.perdeu_ponto && !fd.ganhou_ponto && (tmo != TMO_LAST))
            tmo <= tmo + 1'b1;
        ACERTO:
          if (rounds == ROUNDS_LAST) rounds <= '0;
          else                       rounds <= rounds + 1'b1;
        ERRO:
          if (misses != MISSES_LAST) misses <= misses + 1'b1;
        default: ;
      endcase
    end
  end

  // Moore output decode from the state register
  always_comb begin
    fd.calib_start        = 1'b0;
    fd.trava_servo        = 1'b0;
    fd.start_game         = 1'b0;
    fd.reset_prep_cnt     = 1'b0;
    fd.reset_nivel        = 1'b0;
    fd.reset_nivel_locked = 1'b0;
    fd.gerar_nova_jogada  = 1'b0;
    fd.fade_trigger       = 1'b0;
    fd.conta_nivel        = 1'b0;
    fim_jogo              = 1'b0;
    db_estado             = state;
    case (state)
      IDLE:   fd.trava_servo = 1'b1;
      INIT: begin
        fd.trava_servo        = 1'b1;
        fd.reset_nivel        = 1'b1;
        fd.reset_nivel_locked = 1'b1;
      end
      CALIB:  fd.calib_start = 1'b1;
      SELECT: begin
        fd.start_game     = 1'b1;
        fd.reset_prep_cnt = 1'b1;
      end
      NOVA:   fd.gerar_nova_jogada = 1'b1;
      FADE:   fd.fade_trigger      = 1'b1;
      NIVEL:  fd.conta_nivel       = 1'b1;
      ESPERA: fd.reset_prep_cnt    = 1'b1;
      FIM: begin
        fd.trava_servo = 1'b1;
        fim_jogo       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
